apb_shared_regfile_arb: RTL and testbench
=========================================

APB_SHARED_REGFILE_ARB -- requirements
Module: apb_shared_regfile_arb

Interface
REQ-001 SHALL have parameter: NONE (fixed 16 x 32-bit register bank).
REQ-002 SHALL have port FAB_CLK  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port M2F_RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have APB3 slave ports: PSEL in 1, PENABLE in 1, PWRITE in 1, PADDR in 8 (word index PADDR[5:2]), PWDATA in 32.
REQ-005 SHALL have APB3 slave outputs: PRDATA out 32, PREADY out 1, PSLVERR out 1.
REQ-006 SHALL have fabric port inputs: FAB_REQ in 1 (held until grant), FAB_WE in 1, FAB_ADDR in 4, FAB_WDATA in 32.
REQ-007 SHALL have fabric port outputs: FAB_GNT out 1 (one-cycle access pulse), FAB_RDATA out 32.

Function
REQ-008 SHALL arbitrate one 16 x 32 register bank between APB and fabric; at most one access granted per clock edge.
REQ-009 SHALL implement FSM states IDLE, APB_ACC, FAB_ACC; every state lasts exactly one cycle unless re-entered by a new grant.
REQ-010 SHALL compute at each edge apb_req = PSEL & (state != APB_ACC); fab_req = FAB_REQ & (state != FAB_ACC).
REQ-011 SHALL grant the sole requester; when both request, SHALL grant the one not granted most recently (last_gnt register).
REQ-012 SHALL enter IDLE when neither requests.
REQ-013 SHALL on APB grant edge: commit PWDATA to reg[PADDR[5:2]] if PWRITE, else register reg[PADDR[5:2]] into PRDATA.
REQ-014 SHALL assert PREADY=1 only in APB_ACC; PREADY=0 in all other states.
REQ-015 SHALL give zero wait states when APB wins at its setup edge and exactly one wait state when fabric wins; never more than one.
REQ-016 SHALL on fabric grant edge: commit FAB_WDATA to reg[FAB_ADDR] if FAB_WE, else register reg[FAB_ADDR] into FAB_RDATA.
REQ-017 SHALL assert FAB_GNT=1 only in FAB_ACC; back-to-back fabric accesses SHALL be separated by at least one non-FAB_ACC cycle.
REQ-018 SHALL return pre-write value for a read granted at the same edge a write commits is impossible (single grant); a read granted the edge after a write SHALL return the new value.
REQ-019 SHALL hold PRDATA and FAB_RDATA stable until their next read grant.
REQ-020 SHALL, if PSEL drops after grant, still complete the APB_ACC cycle (write already committed); no recovery action.

Reset
REQ-021 SHALL on M2F_RESET_N=0 asynchronously force: state IDLE, last_gnt=fabric (APB wins first tie), all 16 registers 0, PRDATA=0, FAB_RDATA=0, PREADY=0, PSLVERR=0, FAB_GNT=0.
REQ-022 SHALL abandon any in-flight access on reset; no write commits during reset.

Configuration
REQ-023 SHALL support macro APB_SLVERR_EN.
REQ-024 SHALL, with APB_SLVERR_EN defined, treat PADDR[7:6] != 0 as out-of-range: write dropped, PRDATA=0, PSLVERR=1 during APB_ACC only.
REQ-025 SHALL, without APB_SLVERR_EN, tie PSLVERR=0 and ignore PADDR[7:6] (addresses alias).

Verification
REQ-026 APB write 0xDEADBEEF to PADDR 0x08, no fabric activity -> PREADY=1 first access cycle, reg[2]=0xDEADBEEF; APB read 0x08 returns 0xDEADBEEF.
REQ-027 First-ever tie: APB setup and FAB_REQ same cycle -> APB granted (zero wait), FAB_GNT pulses next cycle.
REQ-028 Second tie after fabric last won -> fabric first, PREADY=0 one cycle then PREADY=1; APB write 0x5 to reg[3], then fabric read addr 3 -> FAB_RDATA=0x5.
REQ-029 FAB_REQ held high continuously, APB idle -> FAB_GNT pattern 1,0,1,0.
REQ-030 With APB_SLVERR_EN, APB write PADDR 0x40 value 0x1 -> PSLVERR=1 with PREADY, reg[0] unchanged; without macro -> PSLVERR=0, reg[0]=0x1.
REQ-031 Assert M2F_RESET_N=0 during APB_ACC -> PREADY=0 immediately, all registers read 0 after release.

Source files
------------

// File: rtl/apb_shared_regfile_arb.sv
// 16 x 32-bit register bank shared between an APB3 slave port and a fabric port, one grant per edge.
// Define APB_SLVERR_EN to flag PADDR[7:6] != 0 as out-of-range with PSLVERR; otherwise addresses alias.
module apb_shared_regfile_arb (
    input  logic        FAB_CLK,
    input  logic        M2F_RESET_N,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        FAB_REQ,
    input  logic        FAB_WE,
    input  logic [3:0]  FAB_ADDR,
    input  logic [31:0] FAB_WDATA,
    output logic        FAB_GNT,
    output logic [31:0] FAB_RDATA
);

    typedef enum logic [1:0] {IDLE, APB_ACC, FAB_ACC} state_t;

    state_t      state;
    state_t      next_state;
    logic        last_gnt_fab;
    logic        apb_req;
    logic        fab_req;
    logic        apb_oor;
    logic [3:0]  apb_idx;
    logic [31:0] regs [16];
    logic        unused_apb;

    assign apb_idx = PADDR[5:2];

`ifdef APB_SLVERR_EN
    logic apb_err;

    assign apb_oor    = |PADDR[7:6];
    assign PSLVERR    = (state == APB_ACC) && apb_err;
    assign unused_apb = ^{PENABLE, PADDR[1:0]};

    // Error flag is captured at the grant edge so it lines up with PREADY in APB_ACC.
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            apb_err <= 1'b0;
        end else if (next_state == APB_ACC) begin
            apb_err <= apb_oor;
        end
    end
`else
    assign apb_oor    = 1'b0;
    assign PSLVERR    = 1'b0;
    assign unused_apb = ^{PENABLE, PADDR[7:6], PADDR[1:0]};
`endif

    // A port that was just served is masked for one cycle, so neither side can starve the other.
    always_comb begin
        apb_req    = PSEL && (state != APB_ACC);
        fab_req    = FAB_REQ && (state != FAB_ACC);
        next_state = IDLE;
        if (apb_req && fab_req) begin
            next_state = last_gnt_fab ? APB_ACC : FAB_ACC;
        end else if (apb_req) begin
            next_state = APB_ACC;
        end else if (fab_req) begin
            next_state = FAB_ACC;
        end
    end

    assign PREADY  = (state == APB_ACC);
    assign FAB_GNT = (state == FAB_ACC);

    // The access itself happens on the grant edge; the following state only signals completion.
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state        <= IDLE;
            last_gnt_fab <= 1'b1;
            PRDATA       <= '0;
            FAB_RDATA    <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= next_state;
            if (next_state == APB_ACC) begin
                last_gnt_fab <= 1'b0;
                if (apb_oor) begin
                    if (!PWRITE) begin
                        PRDATA <= '0;
                    end
                end else if (PWRITE) begin
                    regs[apb_idx] <= PWDATA;
                end else begin
                    PRDATA <= regs[apb_idx];
                end
            end else if (next_state == FAB_ACC) begin
                last_gnt_fab <= 1'b1;
                if (FAB_WE) begin
                    regs[FAB_ADDR] <= FAB_WDATA;
                end else begin
                    FAB_RDATA <= regs[FAB_ADDR];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_shared_regfile_arb.sv
// Self-checking bench for apb_shared_regfile_arb: table-driven cycle vectors plus reset-in-flight sequence.
// Expected PSLVERR/alias behaviour follows APB_SLVERR_EN when the bench is built with it.
module tb_apb_shared_regfile_arb;

    logic        FAB_CLK = 1'b0;
    logic        M2F_RESET_N = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        FAB_REQ = 1'b0;
    logic        FAB_WE = 1'b0;
    logic [3:0]  FAB_ADDR = '0;
    logic [31:0] FAB_WDATA = '0;
    logic        FAB_GNT;
    logic [31:0] FAB_RDATA;

`ifdef APB_SLVERR_EN
    localparam bit SLVERR = 1'b1;
`else
    localparam bit SLVERR = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [7:0]  paddr;
        logic [31:0] pwdata;
        logic        fab_req;
        logic        fab_we;
        logic [3:0]  fab_addr;
        logic [31:0] fab_wdata;
        logic        exp_pready;
        logic        exp_pslverr;
        logic        exp_fab_gnt;
        logic [31:0] exp_prdata;
        logic [31:0] exp_fab_rdata;
    } vec_t;

    vec_t vecs[$];

    apb_shared_regfile_arb dut (
        .FAB_CLK     (FAB_CLK),
        .M2F_RESET_N (M2F_RESET_N),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .FAB_REQ     (FAB_REQ),
        .FAB_WE      (FAB_WE),
        .FAB_ADDR    (FAB_ADDR),
        .FAB_WDATA   (FAB_WDATA),
        .FAB_GNT     (FAB_GNT),
        .FAB_RDATA   (FAB_RDATA)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic psel, input logic pen, input logic pw, input logic [7:0] pa,
                          input logic [31:0] pd, input logic fr, input logic fw, input logic [3:0] fa,
                          input logic [31:0] fd, input logic e_rdy, input logic e_err, input logic e_gnt,
                          input logic [31:0] e_prd, input logic [31:0] e_frd);
        vec_t v;
        v.psel = psel; v.penable = pen; v.pwrite = pw; v.paddr = pa; v.pwdata = pd;
        v.fab_req = fr; v.fab_we = fw; v.fab_addr = fa; v.fab_wdata = fd;
        v.exp_pready = e_rdy; v.exp_pslverr = e_err; v.exp_fab_gnt = e_gnt;
        v.exp_prdata = e_prd; v.exp_fab_rdata = e_frd;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge they depend on.
    task automatic applyStimulus(input vec_t v);
        @(negedge FAB_CLK);
        PSEL = v.psel; PENABLE = v.penable; PWRITE = v.pwrite; PADDR = v.paddr; PWDATA = v.pwdata;
        FAB_REQ = v.fab_req; FAB_WE = v.fab_we; FAB_ADDR = v.fab_addr; FAB_WDATA = v.fab_wdata;
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic apbReadZero(input logic [7:0] addr, input string name);
        @(negedge FAB_CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge FAB_CLK);
        #1;
        checkOutput({name, "_pready"}, {31'b0, PREADY}, 32'd1);
        checkOutput({name, "_prdata"}, PRDATA, 32'd0);
        @(negedge FAB_CLK);
        PENABLE = 1'b1;
        @(posedge FAB_CLK);
        @(negedge FAB_CLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic got;
        logic [31:0] alias_rd;
        alias_rd = SLVERR ? 32'd0 : 32'hDEADBEEF;

        //     psel pen pw paddr  pwdata        freq fwe fa  fwdata        rdy err   gnt prdata            frdata
        addVec(0, 0, 0, 8'h00, 32'h0,         0, 0, 4'd0, 32'h0,        0, 0,      0, 32'h0,            32'h0);
        addVec(1, 0, 1, 8'h08, 32'hDEADBEEF,  1, 0, 4'd2, 32'h0,        1, 0,      0, 32'h0,            32'h0);
        addVec(1, 1, 1, 8'h08, 32'hDEADBEEF,  1, 0, 4'd2, 32'h0,        0, 0,      1, 32'h0,            32'hDEADBEEF);
        addVec(0, 0, 0, 8'h00, 32'h0,         0, 0, 4'd0, 32'h0,        0, 0,      0, 32'h0,            32'hDEADBEEF);
        addVec(1, 0, 0, 8'h08, 32'h0,         0, 0, 4'd0, 32'h0,        1, 0,      0, 32'hDEADBEEF,     32'hDEADBEEF);
        addVec(1, 1, 0, 8'h08, 32'h0,         0, 0, 4'd0, 32'h0,        0, 0,      0, 32'hDEADBEEF,     32'hDEADBEEF);
        addVec(1, 0, 1, 8'h0C, 32'h5,         1, 0, 4'd3, 32'h0,        0, 0,      1, 32'hDEADBEEF,     32'h0);
        addVec(1, 1, 1, 8'h0C, 32'h5,         0, 0, 4'd0, 32'h0,        1, 0,      0, 32'hDEADBEEF,     32'h0);
        addVec(1, 1, 1, 8'h0C, 32'h5,         1, 0, 4'd3, 32'h0,        0, 0,      1, 32'hDEADBEEF,     32'h5);
        addVec(0, 0, 0, 8'h00, 32'h0,         0, 0, 4'd0, 32'h0,        0, 0,      0, 32'hDEADBEEF,     32'h5);
        addVec(0, 0, 0, 8'h00, 32'h0,         1, 0, 4'd2, 32'h0,        0, 0,      1, 32'hDEADBEEF,     32'hDEADBEEF);
        addVec(0, 0, 0, 8'h00, 32'h0,         1, 0, 4'd2, 32'h0,        0, 0,      0, 32'hDEADBEEF,     32'hDEADBEEF);
        addVec(0, 0, 0, 8'h00, 32'h0,         1, 0, 4'd3, 32'h0,        0, 0,      1, 32'hDEADBEEF,     32'h5);
        addVec(0, 0, 0, 8'h00, 32'h0,         1, 0, 4'd3, 32'h0,        0, 0,      0, 32'hDEADBEEF,     32'h5);
        addVec(0, 0, 0, 8'h00, 32'h0,         1, 1, 4'd4, 32'h12345678, 0, 0,      1, 32'hDEADBEEF,     32'h5);
        addVec(0, 0, 0, 8'h00, 32'h0,         0, 0, 4'd0, 32'h0,        0, 0,      0, 32'hDEADBEEF,     32'h5);
        addVec(1, 0, 0, 8'h10, 32'h0,         0, 0, 4'd0, 32'h0,        1, 0,      0, 32'h12345678,     32'h5);
        addVec(1, 1, 0, 8'h10, 32'h0,         0, 0, 4'd0, 32'h0,        0, 0,      0, 32'h12345678,     32'h5);
        addVec(1, 0, 1, 8'h40, 32'h1,         0, 0, 4'd0, 32'h0,        1, SLVERR, 0, 32'h12345678,     32'h5);
        addVec(1, 1, 1, 8'h40, 32'h1,         0, 0, 4'd0, 32'h0,        0, 0,      0, 32'h12345678,     32'h5);
        addVec(1, 0, 0, 8'h00, 32'h0,         0, 0, 4'd0, 32'h0,        1, 0,      0, SLVERR ? 32'h0 : 32'h1, 32'h5);
        addVec(1, 1, 0, 8'h00, 32'h0,         0, 0, 4'd0, 32'h0,        0, 0,      0, SLVERR ? 32'h0 : 32'h1, 32'h5);
        addVec(1, 0, 0, 8'h48, 32'h0,         0, 0, 4'd0, 32'h0,        1, SLVERR, 0, alias_rd,         32'h5);
        addVec(1, 1, 0, 8'h48, 32'h0,         0, 0, 4'd0, 32'h0,        0, 0,      0, alias_rd,         32'h5);

        repeat (2) @(posedge FAB_CLK);
        #1;
        checkOutput("reset_pready", {31'b0, PREADY}, 32'd0);
        checkOutput("reset_pslverr", {31'b0, PSLVERR}, 32'd0);
        checkOutput("reset_fab_gnt", {31'b0, FAB_GNT}, 32'd0);
        checkOutput("reset_prdata", PRDATA, 32'd0);
        checkOutput("reset_fab_rdata", FAB_RDATA, 32'd0);
        @(negedge FAB_CLK);
        M2F_RESET_N = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_pready", i), {31'b0, PREADY}, {31'b0, vecs[i].exp_pready});
            checkOutput($sformatf("v%0d_pslverr", i), {31'b0, PSLVERR}, {31'b0, vecs[i].exp_pslverr});
            checkOutput($sformatf("v%0d_fab_gnt", i), {31'b0, FAB_GNT}, {31'b0, vecs[i].exp_fab_gnt});
            checkOutput($sformatf("v%0d_prdata", i), PRDATA, vecs[i].exp_prdata);
            checkOutput($sformatf("v%0d_fab_rdata", i), FAB_RDATA, vecs[i].exp_fab_rdata);
        end

        // Reset lands in the middle of an APB access cycle; everything must clear at once.
        @(negedge FAB_CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h14; PWDATA = 32'hA5A5A5A5;
        FAB_REQ = 1'b0; FAB_WE = 1'b0;
        @(posedge FAB_CLK);
        #1;
        checkOutput("rst_pre_pready", {31'b0, PREADY}, 32'd1);
        #2;
        M2F_RESET_N = 1'b0;
        #1;
        checkOutput("rst_async_pready", {31'b0, PREADY}, 32'd0);
        checkOutput("rst_async_fab_gnt", {31'b0, FAB_GNT}, 32'd0);
        checkOutput("rst_async_prdata", PRDATA, 32'd0);
        checkOutput("rst_async_fab_rdata", FAB_RDATA, 32'd0);
        @(negedge FAB_CLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'hFFFFFFFF;
        FAB_REQ = 1'b1; FAB_WE = 1'b1; FAB_ADDR = 4'd3; FAB_WDATA = 32'hFFFFFFFF;
        @(posedge FAB_CLK);
        #1;
        checkOutput("rst_held_pready", {31'b0, PREADY}, 32'd0);
        checkOutput("rst_held_fab_gnt", {31'b0, FAB_GNT}, 32'd0);
        @(negedge FAB_CLK);
        M2F_RESET_N = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        FAB_REQ = 1'b0; FAB_WE = 1'b0;

        apbReadZero(8'h08, "post_rst_reg2");
        apbReadZero(8'h0C, "post_rst_reg3");
        apbReadZero(8'h10, "post_rst_reg4");
        apbReadZero(8'h14, "post_rst_reg5");

        @(negedge FAB_CLK);
        FAB_REQ = 1'b1; FAB_WE = 1'b0; FAB_ADDR = 4'd4;
        got = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge FAB_CLK);
            #1;
            if (FAB_GNT) begin
                got = 1'b1;
                break;
            end
        end
        FAB_REQ = 1'b0;
        checkOutput("post_rst_fab_gnt_wait", {31'b0, got}, 32'd1);
        checkOutput("post_rst_fab_rdata", FAB_RDATA, 32'd0);

        repeat (2) @(posedge FAB_CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
